// File: rtl/dac7611_pkg.sv
// dac7611_pkg: shared widths and idle pin levels for the DAC7611 serial monitor
package dac7611_pkg;
    localparam int DAC_DATA_W = 12;
    localparam logic CS_IDLE = 1'b1;
    localparam logic CLK_IDLE = 1'b1;
    localparam logic LD_IDLE = 1'b1;
    localparam logic CLR_IDLE = 1'b1;
    localparam logic SDI_IDLE = 1'b0;
    localparam logic [3:0] BITCNT_MAX = 4'd15;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: single-bit multi-stage synchronizer preloaded to a chosen level on reset
module sync_ff #(
    parameter int SYNC_STAGES = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] r;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r <= {SYNC_STAGES{RESET_VAL}};
        else r <= {r[SYNC_STAGES-2:0], d};
    assign q = r[SYNC_STAGES-1];
endmodule

// File: rtl/dac7611_serial_monitor.sv
// dac7611_serial_monitor: oversampling decoder of the DAC7611 3-wire bus modelling its input and DAC registers
module dac7611_serial_monitor
    import dac7611_pkg::*;
#(
    parameter int DATA_W = DAC_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_50M,
    input  logic              locked,
    input  logic              CS_2,
    input  logic              CLK_3,
    input  logic              SDI_4,
    input  logic              LD_5,
    input  logic              CLR_6,
    output logic [DATA_W-1:0] dac_code,
    output logic [DATA_W-1:0] input_reg,
    output logic              code_valid,
    output logic              frame_err,
    output logic [3:0]        bit_cnt
);
    localparam logic [3:0] FULL = 4'(DATA_W);
    logic cs_s, clk_s, sdi_s, ld_s, clr_s;
    logic cs_d, clk_d, ld_d, clr_d;
    logic [DATA_W-1:0] shift;
    logic cs_fall, cs_rise, clk_rise, ld_fall, clr_fall, shift_en, load;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_cs (.clk(clk_50M), .rst_n(locked), .d(CS_2), .q(cs_s));
    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CLK_IDLE)) u_clk (.clk(clk_50M), .rst_n(locked), .d(CLK_3), .q(clk_s));
    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SDI_IDLE)) u_sdi (.clk(clk_50M), .rst_n(locked), .d(SDI_4), .q(sdi_s));
    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(LD_IDLE)) u_ld (.clk(clk_50M), .rst_n(locked), .d(LD_5), .q(ld_s));
    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CLR_IDLE)) u_clr (.clk(clk_50M), .rst_n(locked), .d(CLR_6), .q(clr_s));

    assign cs_fall = cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;
    assign clk_rise = ~clk_d & clk_s;
    assign ld_fall = ld_d & ~ld_s;
    assign clr_fall = clr_d & ~clr_s;
    // a CLK edge coincident with CS rising sees cs_s=1 and is dropped here
    assign shift_en = clk_rise & ~cs_s;
    assign load = ld_fall & cs_s & clr_s;

    always_ff @(posedge clk_50M or negedge locked) begin
        if (!locked) begin
            cs_d <= CS_IDLE;
            clk_d <= CLK_IDLE;
            ld_d <= LD_IDLE;
            clr_d <= CLR_IDLE;
            shift <= '0;
            bit_cnt <= '0;
            input_reg <= '0;
            dac_code <= '0;
            code_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cs_d <= cs_s;
            clk_d <= clk_s;
            ld_d <= ld_s;
            clr_d <= clr_s;
            if (shift_en) shift <= {shift[DATA_W-2:0], sdi_s};
            bit_cnt <= cs_fall ? {3'd0, shift_en} :
                       (shift_en && bit_cnt != BITCNT_MAX) ? bit_cnt + 4'd1 : bit_cnt;
            if (cs_rise && bit_cnt == FULL) input_reg <= shift;
            frame_err <= cs_rise && bit_cnt != FULL;
            dac_code <= !clr_s ? '0 : load ? input_reg : dac_code;
            code_valid <= clr_fall | load;
        end
    end
endmodule

// File: doc/dac7611_serial_monitor.md
Name: dac7611_serial_monitor

Overview:
Receive-side decoder for the DAC7611 3-wire serial interface (CS/CLK/SDI plus LD and CLR), clocked by clk_50M.
It oversamples the pins driven by the DAC7611P driver, reconstructs the 12-bit word and models the DAC's input and output registers.
It serves as the on-chip loopback checker and as the bench scoreboard source for the DAC path.
It also flags malformed frames.

Parameters:
DATA_W, 12, serial word width (MSB first)
SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2)

Ports:
clk_50M  input  1  system clock, 50 MHz
locked  input  1  asynchronous active-low reset (PLL locked); 0 holds the block in reset
CS_2  input  1  chip select, active low
CLK_3  input  1  serial clock; data is taken on its rising edge
SDI_4  input  1  serial data, MSB first
LD_5  input  1  load strobe, active low; a falling edge transfers the input register to the DAC register
CLR_6  input  1  clear, active low, level-sensitive
dac_code  output  DATA_W  modelled DAC output register
input_reg  output  DATA_W  modelled DAC input register (last complete frame)
code_valid  output  1  one-cycle pulse when dac_code is written (load or clear)
frame_err  output  1  one-cycle pulse at CS rising edge when the bit count is not equal to DATA_W
bit_cnt  output  4  bits received in the current frame; saturates at 15

Behaviour:
- Reset (locked=0, asynchronous):
  - dac_code=0, input_reg=0, shift register=0, bit_cnt=0, code_valid=0, frame_err=0.
  - Synchronizers are preloaded to the idle level: CS, CLK, LD, CLR = 1; SDI = 0. This prevents spurious edges when reset is released.
- Synchronization:
  - Every pin passes through SYNC_STAGES flip-flops.
  - Edge detection compares the synchronized value with a one-cycle delayed copy.
  - SDI uses the same synchronizer depth as CLK, so SDI and CLK stay aligned.
- Supported serial CLK: high and low phases of at least 2 clk_50M periods each (at most 12.5 MHz). Faster clocks are not supported and are not detected.
- Frame start: CS falling edge clears bit_cnt to 0. The shift register is not cleared.
- Shift: on a synchronized CLK rising edge while synchronized CS=0:
  - shift <= {shift[DATA_W-2:0], SDI}
  - bit_cnt <= min(bit_cnt+1, 15)
- CLK edges while CS=1 are ignored.
- Frame end: on the CS rising edge:
  - bit_cnt==DATA_W: input_reg <= shift.
  - Otherwise: frame_err pulses for 1 cycle and input_reg is unchanged.
  - A frame with more than DATA_W bits is an error, even though the shift register holds the last 12 bits.
  - A CLK rising edge in the same cycle as the CS rising edge is ignored.
- Load: LD falling edge while CS=1 → dac_code <= input_reg and code_valid pulses.
  - An LD falling edge while CS=0 is ignored: no pulse, no update.
- Clear: while synchronized CLR=0, dac_code is held at 0.
  - code_valid pulses once, on the CLR falling edge only.
  - input_reg and the shift register are unaffected.
  - CLR has priority over a simultaneous LD edge; that LD is discarded.
- Latency:
  - Pin LD falling edge → code_valid high after SYNC_STAGES+1 cycles (3 at default).
  - The same latency applies to CS rising edge → input_reg update and frame_err.
- Reset mid-frame: all state is cleared. The next frame requires a fresh CS falling edge; the partial frame is discarded with no frame_err.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package dac7611_pkg holds:
  - DAC_DATA_W=12
  - pin idle-level constants (CS/CLK/LD/CLR idle = 1)
  - BITCNT_MAX=15
- Sub-module sync_ff (parameters SYNC_STAGES and RESET_VAL, 1-bit) is instantiated 5 times, once per pin.
- Edge detection, shift, counter and register model stay in the top level.

Test Plan:
1. Drive the DAC7611P driver with Data=12'hAD5 after locked rises → input_reg=0xAD5 at CS rise. After LD, dac_code=0xAD5, one code_valid pulse, frame_err never high.
2. Frame of 11 bits (0x7FF pattern), then CS high → frame_err pulses once and input_reg keeps its previous value 0xAD5. A following LD gives dac_code=0xAD5.
3. Frame of 14 bits: 2'b11 followed by 12'h123 → frame_err pulses, input_reg unchanged, bit_cnt=14.
4. With dac_code=0xAD5, pull CLR_6 low for 10 cycles and pulse LD_5 low during it → dac_code=0 for the whole window, exactly one code_valid pulse, input_reg still 0xAD5. After CLR rises and LD pulses again, dac_code=0xAD5.
5. LD_5 pulsed low while CS_2=0 mid-frame → no code_valid, dac_code unchanged. The frame then completes normally.
6. Deassert locked after 6 bits of a frame, then reassert and send a complete frame of 12'h0F0 → all outputs are 0 during reset, no frame_err, and after LD dac_code=0x0F0.
